// File: rtl/deserializer.sv
// Serial-to-parallel stage: gathers a 1-bit MSB-first stream into left-aligned words.
// Each word comes out with its bit count; short partial frames are dropped and flagged.
module deserializer #(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic              data_i,
  input  logic              data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_mod_o,
  output logic              deser_data_val_o,
  output logic              drop_o,
  output logic              fsm_state_o
);

  // Input side: data_i is consumed on every edge where data_val_i=1. There is no
  // ready; the output strobes (deser_data_val_o, drop_o) last one cycle and must
  // be taken by the consumer in that cycle.

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [MOD_W-1:0] LAST_CNT = MOD_W'(DATA_W - 1);
  localparam logic [MOD_W-1:0] MIN_CNT  = MOD_W'(MIN_LEN);
  localparam logic [MOD_W:0]   FULL_CNT = (MOD_W + 1)'(DATA_W);

  state_t              state_q, state_d;
  logic [MOD_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   shift_in;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [MOD_W-1:0]    mod_q, mod_d;
  logic                val_q, val_d;
  logic                drop_q, drop_d;

  assign shift_in = {shift_q[DATA_W-2:0], data_i};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Accepting here lets a new frame follow a full word or a gap back-to-back.
        if (data_val_i) begin
          shift_d = {{(DATA_W-1){1'b0}}, data_i};
          cnt_d   = MOD_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (data_val_i) begin
          if (cnt_q == LAST_CNT) begin
            data_d  = shift_in;
            mod_d   = '0;
            val_d   = 1'b1;
            cnt_d   = '0;
            shift_d = '0;
            state_d = IDLE;
          end else begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 1'b1;
          end
        end else begin
          // Gap: left-align the pending bits, or discard them if too few.
          if (cnt_q >= MIN_CNT) begin
            data_d = shift_q << (FULL_CNT - {1'b0, cnt_q});
            mod_d  = cnt_q;
            val_d  = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
          cnt_d   = '0;
          shift_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      drop_q  <= drop_d;
    end
  end

  assign deser_data_o     = data_q;
  assign deser_mod_o      = mod_q;
  assign deser_data_val_o = val_q;
  assign drop_o           = drop_q;
  assign fsm_state_o      = state_q;

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: table vectors, hand-written corner sequences and random
// traffic, all compared against a bit-queue model of the framing rules.
module tb_deserializer;

  localparam int DATA_W  = 16;
  localparam int MOD_W   = 4;
  localparam int MIN_LEN = 3;
  localparam int W       = DATA_W + MOD_W;

  logic              clk;
  logic              srst_n;
  logic              data;
  logic              data_val;
  logic [DATA_W-1:0] deser_data;
  logic [MOD_W-1:0]  deser_mod;
  logic              deser_data_val;
  logic              drop;
  logic              fsm_state;

  deserializer #(.DATA_W(DATA_W), .MOD_W(MOD_W), .MIN_LEN(MIN_LEN)) dut (
    .clk_i            (clk),
    .srst_n_i         (srst_n),
    .data_i           (data),
    .data_val_i       (data_val),
    .deser_data_o     (deser_data),
    .deser_mod_o      (deser_mod),
    .deser_data_val_o (deser_data_val),
    .drop_o           (drop),
    .fsm_state_o      (fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: pending bits kept as a plain queue
  logic              bq[$];
  logic [DATA_W-1:0] m_data = '0;
  logic [MOD_W-1:0]  m_mod  = '0;
  logic              m_val  = 1'b0;
  logic              m_drop = 1'b0;
  logic [W-1:0]      exp_q[$];

  task automatic model_emit();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < bq.size(); i++) w[DATA_W-1-i] = bq[i];
    m_data = w;
    m_mod  = MOD_W'(bq.size() % DATA_W);
    m_val  = 1'b1;
    exp_q.push_back({m_mod, m_data});
  endtask

  task automatic model_update(input logic rst_n, input logic v, input logic b);
    m_val  = 1'b0;
    m_drop = 1'b0;
    if (!rst_n) begin
      bq.delete();
      m_data = '0;
      m_mod  = '0;
    end else if (v) begin
      bq.push_back(b);
      if (bq.size() == DATA_W) begin
        model_emit();
        bq.delete();
      end
    end else if (bq.size() > 0) begin
      if (bq.size() >= MIN_LEN) model_emit();
      else m_drop = 1'b1;
      bq.delete();
    end
  endtask

  // driver: one clock cycle of stimulus, then per-cycle scoreboard compare
  task automatic step(input logic rst_n, input logic v, input logic b);
    logic [W-1:0] e;
    @(negedge clk);
    srst_n   = rst_n;
    data_val = v;
    data     = b;
    @(posedge clk);
    cyc++;
    model_update(rst_n, v, b);
    #1;
    check("strobe", 32'(deser_data_val), 32'(m_val));
    check("drop", 32'(drop), 32'(m_drop));
    check("data_hold", 32'(deser_data), 32'(m_data));
    check("mod_hold", 32'(deser_mod), 32'(m_mod));
    check("state_collect", 32'(fsm_state), 32'(bq.size() > 0));
    check("strobe_excl", 32'(deser_data_val & drop), 32'd0);
    if (deser_data_val === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", 32'(deser_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_word", 32'({deser_mod, deser_data}), 32'(e));
      end
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] bits;  // left-aligned, sent MSB first
    int                n;
    logic              exp_val;
    logic              exp_drop;
    logic [DATA_W-1:0] exp_data;
    logic [MOD_W-1:0]  exp_mod;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int strobe_cyc[$];
    logic [DATA_W-1:0] strobe_dat[$];
    int drops;
    logic [DATA_W-1:0] w;

    vecs[0] = '{16'hA5C3, 16, 1'b1, 1'b0, 16'hA5C3, 4'd0};
    vecs[1] = '{16'hB000,  5, 1'b1, 1'b0, 16'hB000, 4'd5};
    vecs[2] = '{16'hC000,  2, 1'b0, 1'b1, 16'hB000, 4'd5};
    vecs[3] = '{16'h5A5A, 16, 1'b1, 1'b0, 16'h5A5A, 4'd0};
    vecs[4] = '{16'hE000,  3, 1'b1, 1'b0, 16'hE000, 4'd3};
    vecs[5] = '{16'h1234, 15, 1'b1, 1'b0, 16'h1234, 4'd15};
    vecs[6] = '{16'h8000,  1, 1'b0, 1'b1, 16'h1234, 4'd15};
    vecs[7] = '{16'hFFFF, 16, 1'b1, 1'b0, 16'hFFFF, 4'd0};

    srst_n = 1'b0; data_val = 1'b0; data = 1'b0;

    // reset and idle
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("rst_data", 32'(deser_data), 32'd0);
    check("rst_mod", 32'(deser_mod), 32'd0);
    check("rst_strobe", 32'(deser_data_val), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    check("idle_strobe", 32'(deser_data_val), 32'd0);
    check("idle_state", 32'(fsm_state), 32'd0);

    // table vectors
    for (int k = 0; k < 8; k++) begin
      w = vecs[k].bits;
      for (int i = 0; i < vecs[k].n; i++) step(1'b1, 1'b1, w[DATA_W-1-i]);
      if (vecs[k].n < DATA_W) step(1'b1, 1'b0, 1'b1);
      check($sformatf("vec%0d_strobe", k), 32'(deser_data_val), 32'(vecs[k].exp_val));
      check($sformatf("vec%0d_drop", k), 32'(drop), 32'(vecs[k].exp_drop));
      check($sformatf("vec%0d_data", k), 32'(deser_data), 32'(vecs[k].exp_data));
      check($sformatf("vec%0d_mod", k), 32'(deser_mod), 32'(vecs[k].exp_mod));
    end
    step(1'b1, 1'b0, 1'b0);

    // back-to-back: 0x1234 then 0xFFFF with no gap
    drops = 0;
    w = 16'h1234;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) w = 16'hFFFF;
      step(1'b1, 1'b1, w[DATA_W-1-(i%16)]);
      if (deser_data_val) begin
        strobe_cyc.push_back(cyc);
        strobe_dat.push_back(deser_data);
      end
      if (drop) drops++;
    end
    step(1'b1, 1'b0, 1'b0);
    check("b2b_count", 32'(strobe_cyc.size()), 32'd2);
    if (strobe_cyc.size() == 2) begin
      check("b2b_spacing", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd16);
      check("b2b_word0", 32'(strobe_dat[0]), 32'h1234);
      check("b2b_word1", 32'(strobe_dat[1]), 32'hFFFF);
    end
    check("b2b_drops", 32'(drops), 32'd0);

    // mid-frame reset then a clean 0x00FF
    strobe_cyc.delete();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("mrst_strobe", 32'(deser_data_val | drop), 32'd0);
    w = 16'h00FF;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, w[DATA_W-1-i]);
      if (deser_data_val) strobe_cyc.push_back(i);
    end
    check("mrst_count", 32'(strobe_cyc.size()), 32'd1);
    if (strobe_cyc.size() == 1) check("mrst_when", 32'(strobe_cyc[0]), 32'd15);
    check("mrst_data", 32'(deser_data), 32'h00FF);
    check("mrst_mod", 32'(deser_mod), 32'd0);

    // random traffic with occasional gaps and resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 8), 1'($urandom));
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Downstream stage of the serializer: consumes its 1-bit serial stream (data + valid) and rebuilds parallel words.
- Each word is output with its significant-bit count, in the same mod encoding the serializer accepts.
- A frame ends in one of two ways: DATA_W bits have been collected, or data_val_i drops (gap) with a partial word pending.
- Partial frames shorter than MIN_LEN are discarded and flagged.

Parameters:
DATA_W, 16, parallel word width; power of two, >= 4
MOD_W, $clog2(DATA_W), width of the bit-count field
MIN_LEN, 3, minimum bit count for a partial frame to be delivered; 1..DATA_W-1

Ports:
clk_i  input  1  single clock, 150 MHz domain
srst_n_i  input  1  reset, synchronous, active-low
data_i  input  1  serial data bit, MSB of the word first
data_val_i  input  1  data_i valid this cycle; deassertion terminates a pending frame
deser_data_o  output  DATA_W  assembled word, left-aligned: first received bit at [DATA_W-1], unused low bits 0
deser_mod_o  output  MOD_W  number of valid bits; 0 encodes DATA_W
deser_data_val_o  output  1  one-cycle strobe: deser_data_o/deser_mod_o valid
drop_o  output  1  one-cycle strobe: short partial frame discarded

Behaviour:
- Clock and reset: one clock clk_i. Reset srst_n_i is synchronous and active-low. All state is sampled on posedge clk_i.
- Reset (srst_n_i=0 at an edge):
  - State goes to IDLE; bit counter, shift register and deser_data_o clear to 0; deser_mod_o=0.
  - deser_data_val_o=0, drop_o=0.
  - A frame in progress when reset hits is lost silently: no strobe, no drop.
- FSM states: IDLE, COLLECT.
  - IDLE, data_val_i=1: shift in data_i, cnt=1, go to COLLECT.
  - IDLE, data_val_i=0: stay.
  - COLLECT, data_val_i=1, cnt<DATA_W-1: shift in, cnt+1.
  - COLLECT, data_val_i=1, cnt=DATA_W-1: full-word event. Bit is taken, word is emitted, cnt=0, go to IDLE.
  - COLLECT, data_val_i=0: gap event. Pending partial is emitted or dropped, cnt=0, go to IDLE.
- Shift register: shifts left, new bit enters at LSB. On emit, left-align by shifting left by DATA_W-cnt; zero fill below.
- Full-word emit:
  - Registered outputs. deser_data_val_o=1 on the cycle after the edge that sampled the last bit.
  - deser_mod_o=0, encoding DATA_W.
- Back-to-back traffic:
  - data_val_i high continuously for k*DATA_W cycles gives k strobes spaced exactly DATA_W cycles apart, with no lost bits.
  - The bit after a full word starts a new frame with no gap required, because IDLE accepts on the same cycle.
- Gap emit: on the edge where data_val_i=0 is sampled in COLLECT with cnt bits pending:
  - cnt >= MIN_LEN: deser_data_val_o=1 next cycle, deser_mod_o=cnt, data left-aligned.
  - cnt < MIN_LEN: drop_o=1 next cycle, deser_data_val_o stays 0, outputs keep their previous values.
- Strobe timing:
  - deser_data_val_o and drop_o are never high together.
  - Each is high for exactly one cycle.
  - A new frame can start on the cycle right after a gap.
- deser_data_o/deser_mod_o hold their last emitted values until the next emit.
- data_i is ignored whenever data_val_i=0.
- No back-pressure: the consumer must accept a strobe in the cycle it occurs.

Test Plan:
- Reset and idle: srst_n_i=0 for 2 cycles, then idle → all outputs 0, no strobes.
- Full word: 16 consecutive valid bits of 0xA5C3, MSB first → one cycle after the 16th bit, deser_data_o=0xA5C3, deser_mod_o=0, single strobe.
- Back-to-back: 32 continuous valid bits carrying 0x1234 then 0xFFFF → strobes exactly 16 cycles apart with those values, drop_o never asserted.
- Partial frame: 5 bits 1,0,1,1,0, then data_val_i=0 → deser_data_o=0xB000, deser_mod_o=5, strobe one cycle after the gap is sampled.
- Short drop: 2 bits then gap (MIN_LEN=3) → drop_o pulse, no data strobe, outputs keep previous values; a following 16-bit word is delivered correctly.
- Mid-frame reset: 9 bits, srst_n_i=0 for 1 cycle, then 16 bits of 0x00FF → no strobe from the aborted frame, then 0x00FF with mod 0.
